serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial signed subtractor computing num1 − num2 one bit per clock, least significant bit first, through a single one-bit full-adder cell. It reports the same result flags as the combinational adder: negative, zero and even, plus signed overflow. Operands enter through a valid/ready handshake, and the result is held under a second valid/ready handshake until it is taken. It sits in the datapath wherever a small-area sequential difference is preferred over a parallel one.

## Interface
- N_BITS, 8, operand and result width; two's-complement signed; must be ≥ 2
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present on num1/num2
- in_ready  output  1  block can accept operands; high only in IDLE
- num1  input  N_BITS  signed minuend; sampled only at acceptance
- num2  input  N_BITS  signed subtrahend; sampled only at acceptance
- out_valid  output  1  diff and flags valid; high only in DONE
- out_ready  input  1  consumer accepts the result
- diff  output  N_BITS  signed num1 − num2, wrapped to N_BITS
- is_negative  output  1  diff[N_BITS-1]
- is_zero  output  1  diff == 0
- is_even  output  1  diff[0] == 0
- overflow  output  1  true difference is outside the signed N_BITS range
- busy  output  1  high in SHIFT

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: computes one bit per cycle.
  - DONE: out_valid=1.
- IDLE → SHIFT when in_valid && in_ready at a rising edge (acceptance). At that edge:
  - a_reg ← num1
  - b_reg ← ~num2
  - carry ← 1
  - bit counter ← 0
  - result shift register ← 0
- SHIFT, every edge:
  - s = a_reg[0] ^ b_reg[0] ^ carry
  - c_out = majority(a_reg[0], b_reg[0], carry)
  - a_reg and b_reg shift right by one.
  - s enters the result register at the MSB, which shifts right.
  - carry ← c_out; counter increments.
  - On the edge that processes bit N_BITS-1: latch overflow = carry_in ^ c_out of that bit, then go to DONE.
- DONE → IDLE on out_valid && out_ready at a rising edge.
- diff and all flags are registered. They update only on the edge entering DONE and hold their values through IDLE until the next result completes.
- in_valid is ignored outside IDLE. Operand changes after acceptance have no effect.
- Width rule: the result is exactly N_BITS with wrap-around; no sign extension.
- Reset (asynchronous, any state, including mid-SHIFT):
  - state → IDLE, aborting any operation in progress
  - all internal registers cleared
  - diff = 0, is_negative = 0, is_zero = 0, is_even = 0, overflow = 0
  - out_valid = 0, busy = 0, in_ready = 1 (follows IDLE)
  - No partial result is ever presented.

## Timing
- Latency: out_valid rises in the cycle after the N_BITS-th edge following acceptance, i.e. N_BITS clocks from the acceptance edge.
- Back-pressure: with out_ready low, DONE holds indefinitely with diff and flags stable.
- Throughput: with out_ready held high and in_valid held high, one result every N_BITS+2 cycles: N_BITS in SHIFT, 1 in DONE, 1 in IDLE.
- No combinational path from any input to any output. in_ready, out_valid and busy decode the state register only.

## Structure
- Package serial_subtractor_pkg:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE}
  - counter width helper function $clog2(N_BITS)
- Sub-module bit_full_adder: ports a, b, cin → s, cout. This is the only arithmetic in the block; it is instantiated once.
- Top level contains the FSM, operand shift registers, carry flop, counter, result register and flag registers.

## Test plan
- Reset, then num1=5, num2=3 → after 8 clocks: diff=2, is_even=1, is_negative=0, is_zero=0, overflow=0.
- num1=3, num2=5 → diff=-2 (8'hFE), is_negative=1, is_even=1, overflow=0. num1=7, num2=7 → diff=0, is_zero=1, is_even=1.
- num1=-128, num2=1 → diff=127, overflow=1. num1=127, num2=-1 → diff=-128, overflow=1, is_negative=1.
- Hold out_ready=0 for 5 cycles in DONE → out_valid, diff and flags stay stable, in_ready stays 0. A new in_valid pulse in that window is ignored, and no second result appears.
- Assert reset_n=0 at cycle 4 of SHIFT → outputs go to reset values immediately (asynchronously). After release, in_ready=1, and a new operand pair gives a correct result.
- Drive in_valid and out_ready continuously with random operand pairs → each result matches the reference model, spaced exactly N_BITS+2 cycles apart.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor shared types.
// FSM state encoding and counter sizing helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_bit_full_adder.sv
// One-bit full adder cell.
// The only arithmetic in the serial subtractor.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial signed subtractor, LSB first.
// Computes num1 - num2 as num1 + ~num2 + 1.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] diff,
  output logic              is_negative,
  output logic              is_zero,
  output logic              is_even,
  output logic              overflow,
  output logic              busy
);

  localparam int CW = cnt_width(N_BITS);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  state_t            state_q;
  logic [N_BITS-1:0] a_q;
  logic [N_BITS-1:0] b_q;
  logic [N_BITS-1:0] res_q;
  logic [N_BITS-1:0] res_d;
  logic [CW-1:0]     cnt_q;
  logic              c_q;
  logic              s;
  logic              c_out;
  logic              ovf_d;
  logic [N_BITS-1:0] diff_q;
  logic              neg_q;
  logic              zero_q;
  logic              even_q;
  logic              ovf_q;

  bit_full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (s),
    .cout (c_out)
  );

  assign res_d = {s, res_q[N_BITS-1:1]};
  assign ovf_d = c_q ^ c_out;

  // FSM, operand shifters, carry, counter, result and flag registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      diff_q  <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      even_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= num1;
            b_q     <= ~num2;
            c_q     <= 1'b1;
            cnt_q   <= '0;
            res_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          c_q   <= c_out;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            neg_q   <= s;
            zero_q  <= (res_d == '0);
            even_q  <= ~res_d[0];
            ovf_q   <= ovf_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == SHIFT);
  assign out_valid   = (state_q == DONE);
  assign diff        = diff_q;
  assign is_negative = neg_q;
  assign is_zero     = zero_q;
  assign is_even     = even_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor.
// Directed vectors plus a streaming throughput run.
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] num1;
  logic [N-1:0] num2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         is_negative;
  logic         is_zero;
  logic         is_even;
  logic         overflow;
  logic         busy;

  int total;
  int bad;

  serial_subtractor #(.N_BITS(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .num1        (num1),
    .num2        (num2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .is_negative (is_negative),
    .is_zero     (is_zero),
    .is_even     (is_even),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // issue one operation and wait for the result, leaving it in DONE
  task automatic start_and_wait(input logic [N-1:0] a,
                                input logic [N-1:0] b,
                                output int lat);
    @(negedge clock);
    chk("rdy_before", in_ready, 1);
    in_valid = 1'b1;
    num1 = a;
    num2 = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    num1 = ~a;
    num2 = ~b;
    chk("busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic consume;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("ov_drop", out_valid, 0);
    chk("rdy_after", in_ready, 1);
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] d;
    logic neg;
    logic zero;
    logic even;
    logic ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    logic [N-1:0] hold_d;
    logic [N-1:0] qa[$];
    logic [N-1:0] qb[$];
    int sent, got, last;
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    num1 = '0;
    num2 = '0;

    vecs[0] = '{8'd5,   8'd3,   8'h02, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'd3,   8'd5,   8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'd7,   8'd7,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h80,  8'd1,   8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h7F,  8'hFF,  8'h80, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (2) @(negedge clock);
    chk("rst_rdy", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {is_negative, is_zero, is_even, overflow}, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      start_and_wait(vecs[i].a, vecs[i].b, lat);
      chk("lat", lat, N);
      chk("diff", diff, vecs[i].d);
      chk("neg", is_negative, vecs[i].neg);
      chk("zero", is_zero, vecs[i].zero);
      chk("even", is_even, vecs[i].even);
      chk("ovf", overflow, vecs[i].ovf);
      consume();
      chk("hold_diff", diff, vecs[i].d);
    end

    // back-pressure: 20 - 45 = -25 = 8'hE7
    start_and_wait(8'd20, 8'd45, lat);
    chk("bp_lat", lat, N);
    hold_d = 8'hE7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      in_valid = (k == 1);
      num1 = 8'd1;
      num2 = 8'd1;
      @(posedge clock);
      #1;
      chk("bp_ov", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      chk("bp_diff", diff, hold_d);
      chk("bp_flags", {is_negative, is_zero, is_even, overflow},
          4'b1000);
    end
    @(negedge clock);
    in_valid = 1'b0;
    consume();
    for (int k = 0; k < N + 4; k++) begin
      @(posedge clock);
      #1;
      chk("no_second", out_valid, 0);
    end

    // asynchronous reset at cycle 4 of SHIFT
    @(negedge clock);
    in_valid = 1'b1;
    num1 = 8'd100;
    num2 = 8'd9;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_rdy", in_ready, 1);
    chk("ar_busy", busy, 0);
    chk("ar_ov", out_valid, 0);
    chk("ar_diff", diff, 0);
    chk("ar_flags", {is_negative, is_zero, is_even, overflow}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("ar_rdy2", in_ready, 1);
    start_and_wait(8'd100, 8'd9, lat);
    chk("ar_lat", lat, N);
    chk("ar_res", diff, 8'd91);
    chk("ar_even", is_even, 0);
    consume();

    // streaming: one result every N+2 cycles
    sent = 0;
    got = 0;
    last = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 * (N + 2) + 20 && got < 10; cyc++) begin
      @(negedge clock);
      if (in_ready) begin
        if (sent < 10) begin
          num1 = N'($urandom);
          num2 = N'($urandom);
          in_valid = 1'b1;
          qa.push_back(num1);
          qb.push_back(num2);
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clock);
      #1;
      if (out_valid) begin
        logic [N-1:0] ea, eb, ed;
        logic eo;
        ea = qa.pop_front();
        eb = qb.pop_front();
        ed = ea - eb;
        eo = (ea[N-1] != eb[N-1]) && (ed[N-1] != ea[N-1]);
        chk("st_diff", diff, ed);
        chk("st_ovf", overflow, eo);
        chk("st_zero", is_zero, ed == 0);
        if (got > 0) chk("st_gap", cyc - last, N + 2);
        last = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("st_count", got, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
